mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
//
// PURPOSE
// Shares the single-port memory2c between the instruction-fetch path and the
// data-memory path of the unpipelined core. Grants at most one requester per
// cycle, drives the memory address/control, and returns read data registered
// one cycle later. The denied side is stalled.
//
// PARAMETERS
// ADDR_W      16  address width (byte address)
// DATA_W      16  data word width
// STARVE_MAX  3   consecutive denied fetch cycles before fetch wins priority
//
// PORTS
// clk        in   1       clock
// rst        in   1       synchronous reset, active-high
// i_req      in   1       fetch read request
// i_addr     in   ADDR_W  fetch address (PC)
// i_stall    out  1       fetch denied this cycle (combinational)
// i_done     out  1       fetch response valid, one cycle after grant
// i_rdata    out  DATA_W  fetched instruction (registered)
// d_req      in   1       data access request
// d_wr       in   1       1 = write, 0 = read
// d_addr     in   ADDR_W  data address
// d_wdata    in   DATA_W  write data
// d_stall    out  1       data denied this cycle (combinational)
// d_done     out  1       data response valid, one cycle after grant
// d_rdata    out  DATA_W  load data (registered)
// mem_enable out  1       to memory2c.enable
// mem_wr     out  1       to memory2c.wr
// mem_addr   out  ADDR_W  to memory2c.addr
// mem_wdata  out  DATA_W  to memory2c.data_in
// mem_rdata  in   DATA_W  from memory2c.data_out (combinational read)
// err        out  1       misaligned granted access; pulses with the done
//
// BEHAVIOUR
// - Reset: i_done=d_done=err=0, i_rdata=d_rdata=0, owner=NONE, starve_cnt=0.
//   A grant issued in the cycle rst is high is discarded; no done follows.
// - Grant (combinational): if d_req && !(i_req && starve_cnt==STARVE_MAX)
//   -> grant D; else if i_req -> grant I; else none.
// - starve_cnt: +1 when i_req && grant D (saturates at STARVE_MAX); cleared
//   when grant I or !i_req.
// - i_stall = i_req & ~grant_I; d_stall = d_req & ~grant_D. Requesters hold
//   req/addr/wdata stable while stalled.
// - Memory drive: grant none -> mem_enable=0, mem_wr=0. Grant I -> addr=i_addr,
//   wr=0. Grant D -> addr=d_addr, wr=d_wr, wdata=d_wdata.
// - Misaligned (granted addr[0]=1): mem_enable=0 (write suppressed); the done
//   still pulses next cycle with err=1; rdata register unchanged.
// - Owner FSM, registered each edge: NONE / OWN_I / OWN_D = grant just issued.
//   OWN_I: i_done=1, i_rdata<=mem_rdata captured at grant edge.
//   OWN_D read: d_done=1, d_rdata<=mem_rdata. OWN_D write: d_done=1,
//   d_rdata holds. NONE: both done=0.
// - Latency: request granted in cycle N -> done in N+1; back-to-back grants
//   give one done per cycle. Each rdata holds its value until its next read.
// - Simultaneous i_req & d_req every cycle: pattern D,D,D,I repeating for
//   STARVE_MAX=3 (fetch never starves indefinitely).
//
// STRUCTURE
// - mem_arb_defs.vh: owner encoding OWN_NONE=2'b00, OWN_I=2'b01,
//   OWN_D=2'b10; default widths.
// - Sub-module mem_arb_grant: combinational grant + starve counter register;
//   the top holds owner FSM, response registers, memory mux, err.
//
// TESTING
// - Reset held 2 cycles with i_req=d_req=1 -> no done, err=0; rdata=0.
// - i_req only, i_addr=0x0004 -> i_stall=0, mem_addr=0x0004; next cycle
//   i_done=1, i_rdata=mem[0x0004].
// - d_req write 0xBEEF @0x0010 with i_req -> d granted, i_stall=1; next cycle
//   d_done=1; later fetch of 0x0010 returns 0xBEEF.
// - Both requests held 8 cycles, STARVE_MAX=3 -> grants D,D,D,I,D,D,D,I.
// - d_req write @0x0011 -> mem_enable=0, next cycle d_done=1, err=1;
//   memory at 0x0010 unchanged.
// - rst asserted in grant cycle of a fetch -> next cycle i_done=0, owner NONE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: default widths and owner encoding.
// Owner encoding records which requester was granted in the previous cycle,
// and therefore which response port pulses its done this cycle.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 16;
  localparam int STARVE_MAX_DEF = 3;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } owner_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant logic: data side wins by default, fetch wins once it has been denied
// STARVE_MAX consecutive cycles. Grant is combinational; only the starve
// counter is registered.
// Ports: clk, rst (sync, active-high), i_req/d_req in, grant_i/grant_d out.
import mem_arbiter_pkg::*;

module mem_arb_grant #(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic d_req,
  output logic grant_i,
  output logic grant_d
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;

  always_comb begin
    grant_d  = d_req && !(i_req && (starve_q == STARVE_LIM));
    grant_i  = i_req && !grant_d;
    // Counter only grows while fetch is waiting behind data; any fetch grant
    // or an idle fetch side restarts the count.
    starve_d = '0;
    if (i_req && grant_d) begin
      starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Ports: fetch req/addr -> stall/done/rdata; data req/wr/addr/wdata ->
// stall/done/rdata; memory enable/wr/addr/wdata out, rdata in; err out.
// Responses (done, rdata, err) appear one cycle after the grant.
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_stall,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_stall,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  logic grant_i;
  logic grant_d;
  logic misaligned;

  owner_e            owner_q,   owner_d;
  logic              err_q,     err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  mem_arb_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .d_req   (d_req),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  always_comb begin
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (grant_d) begin
      mem_addr  = d_addr;
      mem_wr    = d_wr;
      mem_wdata = d_wdata;
    end else if (grant_i) begin
      mem_addr  = i_addr;
    end

    // Odd byte address on a word memory: keep the access off the memory so
    // a bad store cannot corrupt the neighbouring word. Grants made during
    // reset are discarded, so they never reach the memory either.
    misaligned = (grant_i || grant_d) && mem_addr[0];
    mem_enable = (grant_i || grant_d) && !misaligned && !rst;

    i_stall = i_req && !grant_i;
    d_stall = d_req && !grant_d;

    owner_d = grant_d ? OWN_D : (grant_i ? OWN_I : OWN_NONE);
    err_d   = misaligned;

    // Read data is captured at the edge closing the grant cycle; writes and
    // misaligned accesses leave the response register holding its old value.
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    if (grant_i && !misaligned) begin
      i_rdata_d = mem_rdata;
    end
    if (grant_d && !d_wr && !misaligned) begin
      d_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= OWN_NONE;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      owner_q   <= owner_d;
      err_q     <= err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign i_done  = (owner_q == OWN_I);
  assign d_done  = (owner_q == OWN_D);
  assign err     = err_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_stall, i_done, d_stall, d_done, err;
  logic [15:0] i_rdata, d_rdata;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_stall(i_stall), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_stall(d_stall), .d_done(d_done), .d_rdata(d_rdata),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err(err)
  );

  // Word memory model: unwritten word k reads as 0x1000 + k.
  logic [15:0] mem [0:127];
  bit          wrt [0:127];
  logic [6:0]  widx;
  assign widx      = mem_addr[7:1];
  assign mem_rdata = wrt[widx] ? mem[widx] : (16'h1000 + {9'd0, widx});

  always @(posedge clk) begin
    if (mem_enable && mem_wr) begin
      mem[widx] <= mem_wdata;
      wrt[widx] <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        x_i_stall;
    logic        x_d_stall;
    logic        x_mem_en;
    logic        x_mem_wr;
    logic [15:0] x_mem_addr;
    logic        x_i_done;
    logic        x_d_done;
    logic        x_err;
    logic [15:0] x_i_rdata;
    logic [15:0] x_d_rdata;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // Expected values assume starve count 0 entering each vector (none of
    // these vectors leaves fetch denied twice in a row).
    //            ireq iaddr     dreq dwr daddr     dwdata    ist dst en wr maddr     idn ddn err irdata    drdata
    vecs[0] = '{1'b1, 16'h0004, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b0, 16'h1002, 16'h0000};
    vecs[1] = '{1'b1, 16'h0010, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b1, 1'b0, 16'h1002, 16'h0000};
    vecs[2] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h0000};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b1, 1'b0, 16'hBEEF, 16'h1002};
    vecs[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h1002};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0011, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b0, 1'b1, 1'b1, 16'hBEEF, 16'h1002};
    vecs[6] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h1002};
    vecs[7] = '{1'b1, 16'h0005, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b1, 16'hBEEF, 16'h1002};

    // Reset held two cycles with both requests active.
    rst = 1'b1; i_req = 1'b1; i_addr = 16'h0004;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0008; d_wdata = 16'h0000;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rst%0d i_done", c), {31'd0, i_done}, 0);
      chk($sformatf("rst%0d d_done", c), {31'd0, d_done}, 0);
      chk($sformatf("rst%0d err", c), {31'd0, err}, 0);
      chk($sformatf("rst%0d i_rdata", c), {16'd0, i_rdata}, 0);
      chk($sformatf("rst%0d d_rdata", c), {16'd0, d_rdata}, 0);
    end
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      i_req = vecs[v].i_req; i_addr = vecs[v].i_addr;
      d_req = vecs[v].d_req; d_wr = vecs[v].d_wr;
      d_addr = vecs[v].d_addr; d_wdata = vecs[v].d_wdata;
      #1;
      chk($sformatf("v%0d i_stall", v), {31'd0, i_stall}, {31'd0, vecs[v].x_i_stall});
      chk($sformatf("v%0d d_stall", v), {31'd0, d_stall}, {31'd0, vecs[v].x_d_stall});
      chk($sformatf("v%0d mem_enable", v), {31'd0, mem_enable}, {31'd0, vecs[v].x_mem_en});
      chk($sformatf("v%0d mem_wr", v), {31'd0, mem_wr}, {31'd0, vecs[v].x_mem_wr});
      chk($sformatf("v%0d mem_addr", v), {16'd0, mem_addr}, {16'd0, vecs[v].x_mem_addr});
      @(posedge clk); #1;
      chk($sformatf("v%0d i_done", v), {31'd0, i_done}, {31'd0, vecs[v].x_i_done});
      chk($sformatf("v%0d d_done", v), {31'd0, d_done}, {31'd0, vecs[v].x_d_done});
      chk($sformatf("v%0d err", v), {31'd0, err}, {31'd0, vecs[v].x_err});
      chk($sformatf("v%0d i_rdata", v), {16'd0, i_rdata}, {16'd0, vecs[v].x_i_rdata});
      chk($sformatf("v%0d d_rdata", v), {16'd0, d_rdata}, {16'd0, vecs[v].x_d_rdata});
    end

    // Both sides requesting for 8 cycles: grants D,D,D,I,D,D,D,I.
    i_req = 1'b1; i_addr = 16'h0006; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0008;
    for (int k = 0; k < 8; k++) begin
      logic gi;
      gi = (k % 4 == 3);
      #1;
      chk($sformatf("starve%0d i_stall", k), {31'd0, i_stall}, {31'd0, !gi});
      chk($sformatf("starve%0d d_stall", k), {31'd0, d_stall}, {31'd0, gi});
      chk($sformatf("starve%0d mem_addr", k), {16'd0, mem_addr}, gi ? 32'h0006 : 32'h0008);
      @(posedge clk); #1;
      chk($sformatf("starve%0d i_done", k), {31'd0, i_done}, {31'd0, gi});
      chk($sformatf("starve%0d d_done", k), {31'd0, d_done}, {31'd0, !gi});
      if (gi) chk($sformatf("starve%0d i_rdata", k), {16'd0, i_rdata}, 32'h1003);
      else    chk($sformatf("starve%0d d_rdata", k), {16'd0, d_rdata}, 32'h1004);
    end

    // Reset asserted in the grant cycle of a fetch: that grant yields no done.
    i_req = 1'b1; i_addr = 16'h0004; d_req = 1'b0; rst = 1'b1;
    #1;
    chk("rstgrant i_stall", {31'd0, i_stall}, 0);
    @(posedge clk); #1;
    rst = 1'b0; i_addr = 16'h0010;
    chk("rstgrant i_done", {31'd0, i_done}, 0);
    chk("rstgrant d_done", {31'd0, d_done}, 0);
    chk("rstgrant i_rdata", {16'd0, i_rdata}, 0);
    chk("rstgrant err", {31'd0, err}, 0);

    // Word at 0x0010 still holds the earlier store; the misaligned write missed it.
    @(posedge clk); #1;
    chk("post i_done", {31'd0, i_done}, 1);
    chk("post i_rdata", {16'd0, i_rdata}, 32'hBEEF);

    i_req = 1'b0;
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
